ex_operand_stage: RTL

- ID/EX pipeline register and operand-select stage directly upstream of the ALU in the pipelined MIPS core.
- Latches decoded operands and controls, applies EX/MEM and MEM/WB forwarding, and selects shamt/immediate.
- Drives the ALU's A, B and ALUOp inputs.
- Detects load-use hazards and requests a front-end stall.

---
 rtl/ex_operand_stage.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register and ALU operand select, with forwarding and load-use stall detection.
// Optional macro EX_FORWARD_EN enables EX/MEM and MEM/WB forwarding; without it every RAW hazard stalls.
module ex_operand_stage #(
    parameter int unsigned DW     = 32,
    parameter logic [3:0]  NOP_OP = 4'd0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] id_rd1,
    input  logic [DW-1:0] id_rd2,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_shamt,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic [4:0]    id_wreg,
    input  logic [3:0]    id_aluop,
    input  logic          id_alusrc_b,
    input  logic          id_shift_sa,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          mem_regwrite,
    input  logic [4:0]    mem_wreg,
    input  logic [DW-1:0] mem_result,
    input  logic          wb_regwrite,
    input  logic [4:0]    wb_wreg,
    input  logic [DW-1:0] wb_result,
    input  logic          flush,
    input  logic          ex_hold,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_op,
    output logic [DW-1:0] ex_store_data,
    output logic [4:0]    ex_wreg,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic          load_use_stall
);

    typedef struct packed {
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic [4:0]    shamt;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic [4:0]    wreg;
        logic [3:0]    aluop;
        logic          alusrc_b;
        logic          shift_sa;
        logic          regwrite;
        logic          memread;
        logic          memwrite;
    } ex_reg_t;

    ex_reg_t q;
    ex_reg_t id_pkt;
    ex_reg_t bubble;
    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;
    logic          rs_hit_ex;
    logic          rt_hit_ex;

    always_comb begin
        bubble       = '0;
        bubble.aluop = NOP_OP;
        id_pkt       = '0;
        id_pkt.rd1      = id_rd1;
        id_pkt.rd2      = id_rd2;
        id_pkt.imm      = id_imm;
        id_pkt.shamt    = id_shamt;
        id_pkt.rs       = id_rs;
        id_pkt.rt       = id_rt;
        id_pkt.wreg     = id_wreg;
        id_pkt.aluop    = id_aluop;
        id_pkt.alusrc_b = id_alusrc_b;
        id_pkt.shift_sa = id_shift_sa;
        id_pkt.regwrite = id_regwrite;
        id_pkt.memread  = id_memread;
        id_pkt.memwrite = id_memwrite;
    end

    // Flush beats hold; a stall inserts a bubble behind the instruction in EX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= bubble;
        end else if (flush) begin
            q <= bubble;
        end else if (!ex_hold) begin
            q <= load_use_stall ? bubble : id_pkt;
        end
    end

    always_comb begin
        rs_hit_ex = (q.wreg != 5'd0) && id_use_rs && (id_rs == q.wreg);
        rt_hit_ex = (q.wreg != 5'd0) && id_use_rt && (id_rt == q.wreg);
    end

`ifdef EX_FORWARD_EN
    // MEM result is younger than WB, so it wins; r0 is never forwarded.
    always_comb begin
        fwd_a = q.rd1;
        if (mem_regwrite && (mem_wreg != 5'd0) && (mem_wreg == q.rs)) begin
            fwd_a = mem_result;
        end else if (wb_regwrite && (wb_wreg != 5'd0) && (wb_wreg == q.rs)) begin
            fwd_a = wb_result;
        end
        fwd_b = q.rd2;
        if (mem_regwrite && (mem_wreg != 5'd0) && (mem_wreg == q.rt)) begin
            fwd_b = mem_result;
        end else if (wb_regwrite && (wb_wreg != 5'd0) && (wb_wreg == q.rt)) begin
            fwd_b = wb_result;
        end
    end

    assign load_use_stall = q.memread && (rs_hit_ex || rt_hit_ex);
`else
    logic rs_hit_late;
    logic rt_hit_late;
    logic unused_fwd;

    assign fwd_a      = q.rd1;
    assign fwd_b      = q.rd2;
    assign unused_fwd = ^{mem_result, wb_result};

    // Without bypass paths, any in-flight writer of a source register must drain first.
    always_comb begin
        rs_hit_late = id_use_rs && (id_rs != 5'd0) &&
                      ((mem_regwrite && (mem_wreg == id_rs)) || (wb_regwrite && (wb_wreg == id_rs)));
        rt_hit_late = id_use_rt && (id_rt != 5'd0) &&
                      ((mem_regwrite && (mem_wreg == id_rt)) || (wb_regwrite && (wb_wreg == id_rt)));
    end

    assign load_use_stall = (q.regwrite && (rs_hit_ex || rt_hit_ex)) || rs_hit_late || rt_hit_late;
`endif

    assign alu_a         = q.shift_sa ? DW'(q.shamt) : fwd_a;
    assign alu_b         = q.alusrc_b ? q.imm : fwd_b;
    assign alu_op        = q.aluop;
    assign ex_store_data = fwd_b;
    assign ex_wreg       = q.wreg;
    assign ex_regwrite   = q.regwrite;
    assign ex_memread    = q.memread;
    assign ex_memwrite   = q.memwrite;

endmodule
